// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex driver for a common-anode 7-segment display.
// The divided scan clock is synchronized and edge-detected on clk_in to pace the digits.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        scan_clk,
    input  logic [4*N_DIGITS-1:0]       value,
    input  logic [N_DIGITS-1:0]         dp_mask,
    output logic [N_DIGITS-1:0]         anodes,
    output logic [6:0]                  segments,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned VAL_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state;
    logic               scan_meta;
    logic               scan_sync;
    logic               scan_prev;
    logic [CNT_W-1:0]   guard_cnt;
    logic [VAL_W-1:0]   shadow_val;
    logic [N_DIGITS-1:0] shadow_dp;

    logic                tick_c;
    logic                wrap_c;
    logic                capture_c;
    logic [IDX_W-1:0]    next_idx_c;
    logic [IDX_W-1:0]    show_idx_c;
    logic [VAL_W-1:0]    src_val_c;
    logic [N_DIGITS-1:0] src_dp_c;
    logic [N_DIGITS-1:0] show_an_c;
    logic [6:0]          show_seg_c;
    logic                show_dp_c;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Segment pattern for one digit, blanking it when it and every higher nibble are zero.
    function automatic logic [6:0] digit_segs(input logic [VAL_W-1:0] v,
                                              input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        logic       upper_zero;
        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (i == int'(idx)) nib = v[4*i +: 4];
            if ((i >= int'(idx)) && (v[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
        end
        if ((LZ_BLANK != 0) && (idx != '0) && upper_zero) return 7'h7F;
        return hex7(nib);
    endfunction

    // Shadow is reloaded only when the scan starts a new frame at digit 0.
    always_comb begin
        tick_c     = scan_sync & ~scan_prev;
        wrap_c     = (digit_idx == LAST_IDX);
        next_idx_c = wrap_c ? '0 : digit_idx + IDX_W'(1);
        capture_c  = tick_c && ((state == IDLE) || ((state == SHOW) && wrap_c));
        src_val_c  = capture_c ? value : shadow_val;
        src_dp_c   = capture_c ? dp_mask : shadow_dp;
        show_idx_c = digit_idx;
        if (state == IDLE)      show_idx_c = '0;
        else if (state == SHOW) show_idx_c = next_idx_c;
        show_an_c  = ~(N_DIGITS'(1) << show_idx_c);
        show_seg_c = digit_segs(src_val_c, show_idx_c);
        show_dp_c  = ~src_dp_c[show_idx_c];
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            scan_meta  <= 1'b0;
            scan_sync  <= 1'b0;
            scan_prev  <= 1'b0;
            guard_cnt  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            digit_idx  <= '0;
            anodes     <= '1;
            segments   <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            scan_meta <= scan_clk;
            scan_sync <= scan_meta;
            scan_prev <= scan_sync;
            if (capture_c) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
            end
            case (state)
                IDLE: begin
                    if (tick_c) begin
                        digit_idx <= '0;
                        guard_cnt <= '0;
                        if (GUARD_CYCLES == 0) begin
                            state    <= SHOW;
                            anodes   <= show_an_c;
                            segments <= show_seg_c;
                            dp       <= show_dp_c;
                        end else begin
                            state <= BLANK;
                        end
                    end
                end
                SHOW: begin
                    if (tick_c) begin
                        digit_idx <= next_idx_c;
                        guard_cnt <= '0;
                        if (GUARD_CYCLES == 0) begin
                            anodes   <= show_an_c;
                            segments <= show_seg_c;
                            dp       <= show_dp_c;
                        end else begin
                            state    <= BLANK;
                            anodes   <= '1;
                            segments <= 7'h7F;
                            dp       <= 1'b1;
                        end
                    end
                end
                BLANK: begin
                    // Ticks landing in the gap are intentionally ignored.
                    if (guard_cnt == CNT_LAST) begin
                        state    <= SHOW;
                        anodes   <= show_an_c;
                        segments <= show_seg_c;
                        dp       <= show_dp_c;
                    end else begin
                        guard_cnt <= guard_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    anodes   <= '1;
                    segments <= 7'h7F;
                    dp       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver: 4 digits, 2-cycle gap (and a 4-cycle gap instance).
module tb_seg7_scan_driver;

    localparam int unsigned N = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        scan_a = 1'b0;
    logic        scan_b = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;

    logic [3:0]  anodes, anodes_b;
    logic [6:0]  segments, segments_b;
    logic        dp, dp_b;
    logic [1:0]  digit_idx, digit_idx_b;

    always #5 clk_in = ~clk_in;

    seg7_scan_driver #(.N_DIGITS(4), .GUARD_CYCLES(2), .LZ_BLANK(1)) dut (
        .clk_in(clk_in), .reset(reset), .scan_clk(scan_a), .value(value), .dp_mask(dp_mask),
        .anodes(anodes), .segments(segments), .dp(dp), .digit_idx(digit_idx)
    );

    seg7_scan_driver #(.N_DIGITS(4), .GUARD_CYCLES(4), .LZ_BLANK(1)) dut_g4 (
        .clk_in(clk_in), .reset(reset), .scan_clk(scan_b), .value(value), .dp_mask(dp_mask),
        .anodes(anodes_b), .segments(segments_b), .dp(dp_b), .digit_idx(digit_idx_b)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    int          checks = 0;
    int          failures = 0;
    int          m_idx = -1;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp = 4'b0000;

    function automatic logic [6:0] ref_seg(input logic [15:0] v, input int idx);
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [6:0]  seg;
        upper = v >> (4 * idx);
        nib   = upper[3:0];
        if (idx > 0 && upper == 16'h0000) return 7'h7F;
        case (nib)
            4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame model: advance digit, reloading the snapshot at each frame start.
    task automatic push_tick();
        exp_t e;
        if (m_idx < 0 || m_idx == int'(N) - 1) begin
            m_idx = 0;
            m_val = value;
            m_dp  = dp_mask;
        end else begin
            m_idx++;
        end
        e.an  = ~(4'b0001 << m_idx);
        e.seg = ref_seg(m_val, m_idx);
        e.dp  = ~m_dp[m_idx];
        e.idx = 2'(m_idx);
        sb.push_back(e);
    endtask

    task automatic step_a(input string tag);
        exp_t e;
        @(negedge clk_in);
        scan_a = 1'b1;
        push_tick();
        repeat (2) @(posedge clk_in);
        @(posedge clk_in); #1;
        chk({tag, "_gap0"}, 32'({anodes, segments, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        @(posedge clk_in); #1;
        chk({tag, "_gap1"}, 32'({anodes, segments, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        @(posedge clk_in); #1;
        e = sb.pop_front();
        last_exp = e;
        chk(tag, 32'({anodes, segments, dp, digit_idx}), 32'(e));
        @(negedge clk_in);
        scan_a = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        // Reset and idle with scan_clk low
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            chk("idle", 32'({anodes, segments, dp, digit_idx}), 32'({4'hF, 7'h7F, 1'b1, 2'd0}));
        end

        // Basic scan of 12AF
        value   = 16'h12AF;
        dp_mask = 4'b0100;
        step_a("d0_F");
        step_a("d1_A");
        step_a("d2_2_dp");
        step_a("d3_1");

        // Shadow coherence across a mid-frame value change
        value = 16'h1234;
        step_a("sh_d0");
        step_a("sh_d1");
        step_a("sh_d2");
        value = 16'h5678;
        step_a("sh_d3_old");
        step_a("sh_wrap_d0");
        step_a("sh_d1_new");
        step_a("sh_d2_new");
        step_a("sh_d3_new");

        // Leading-zero blanking
        value = 16'h0005;
        step_a("lz_d0_5");
        step_a("lz_d1_blank");
        step_a("lz_d2_blank_dp");
        step_a("lz_d3_blank");
        value = 16'h0000;
        step_a("lz_d0_zero");
        step_a("lz_d1");
        step_a("lz_d2");
        step_a("lz_d3");

        // Asynchronous reset while digit 3 is shown
        @(posedge clk_in); #2;
        reset = 1'b0;
        #1;
        chk("async_rst", 32'({anodes, segments, dp, digit_idx}), 32'({4'hF, 7'h7F, 1'b1, 2'd0}));
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        m_idx = -1;
        sb.delete();
        value = 16'hABCD;
        step_a("rst_restart_d0");

        // Scan clock held constant: display stays on the current digit
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(negedge clk_in);
            chk("frozen", 32'({anodes, segments, dp, digit_idx}), 32'(last_exp));
        end

        // Tick arriving inside a 4-cycle gap is dropped
        @(negedge clk_in);
        scan_b = 1'b1;
        repeat (10) @(negedge clk_in);
        scan_b = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("g4_first", 32'({anodes_b, segments_b, digit_idx_b}), 32'({4'b1110, 7'b0100001, 2'd0}));
        @(negedge clk_in);
        scan_b = 1'b1;
        @(negedge clk_in);
        scan_b = 1'b0;
        @(negedge clk_in);
        scan_b = 1'b1;
        repeat (12) @(negedge clk_in);
        chk("g4_drop", 32'({anodes_b, segments_b, digit_idx_b}), 32'({4'b1101, 7'b1000110, 2'd1}));
        scan_b = 1'b0;
        repeat (20) @(negedge clk_in);
        chk("g4_hold", 32'({anodes_b, segments_b, digit_idx_b}), 32'({4'b1101, 7'b1000110, 2'd1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
